// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame controller: FSM state encoding,
// error codes and the default frame start marker.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_OPC  = 3'd1,
    ST_LEN  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

  localparam logic [1:0] ERR_OVR = 2'd0;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] SYNC_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_frame_chk.sv
// XOR checksum accumulator: load starts a new sum, en folds a byte in,
// match compares the running sum against the byte currently presented.
module uart_frame_chk (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] data,
  output logic [7:0] acc,
  output logic       match
);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 8'd0;
    end else if (load) begin
      acc <= data;
    end else if (en) begin
      acc <= acc ^ data;
    end
  end

  assign match = (acc == data);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Assembles SYNC/OPCODE/LEN/PAYLOAD/CHK frames from uart_rx byte strobes and
// hands validated commands downstream. Optional inter-byte timeout: UART_FRAME_TIMEOUT_EN.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_ready,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_opcode,
  output logic [3:0]           cmd_len,
  output logic [MAX_LEN*8-1:0] cmd_payload,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic                 busy
);

  if (MAX_LEN < 1 || MAX_LEN > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
    $error("uart_frame_ctrl: MAX_LEN must be 1..15 and TIMEOUT_CYC 1..65535");
  end

  state_t     state;
  logic [3:0] idx;
  logic [7:0] chk_acc;
  logic       chk_match;
  logic       tmo_hit;
  logic       strobe;
  logic       len_ok;

`ifdef UART_FRAME_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        in_frame;

  assign in_frame = (state == ST_OPC) || (state == ST_LEN) ||
                    (state == ST_PAY) || (state == ST_CHK);
  assign tmo_hit  = in_frame && (tmo_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_frame || tmo_hit || rx_ready) begin
      tmo_cnt <= 16'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Expiry wins over a byte arriving in the same cycle.
  assign strobe = rx_ready && !tmo_hit;
  assign len_ok = (rx_data <= 8'(MAX_LEN));

  uart_frame_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .load  (strobe && (state == ST_OPC)),
    .en    (strobe && (((state == ST_LEN) && len_ok) || (state == ST_PAY))),
    .data  (rx_data),
    .acc   (chk_acc),
    .match (chk_match)
  );

  assign busy = (state != ST_IDLE);

  // Command handshake: cmd_valid rises one cycle after a good CHK byte and the
  // command fields stay frozen until the cycle where cmd_valid && cmd_ready,
  // which consumes it; cmd_valid never drops without that handshake (except rst).
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= 4'd0;
      cmd_valid   <= 1'b0;
      cmd_opcode  <= 8'd0;
      cmd_len     <= 4'd0;
      cmd_payload <= '0;
      err_pulse   <= 1'b0;
      err_code    <= ERR_OVR;
    end else begin
      err_pulse <= 1'b0;
      if (tmo_hit) begin
        err_pulse <= 1'b1;
        err_code  <= ERR_TMO;
        state     <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (strobe && (rx_data == SYNC_BYTE)) state <= ST_OPC;
          end
          ST_OPC: begin
            if (strobe) begin
              cmd_opcode <= rx_data;
              state      <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (strobe) begin
              if (!len_ok) begin
                err_pulse <= 1'b1;
                err_code  <= ERR_LEN;
                state     <= ST_IDLE;
              end else begin
                cmd_len     <= rx_data[3:0];
                cmd_payload <= '0;
                idx         <= 4'd0;
                state       <= (rx_data[3:0] == 4'd0) ? ST_CHK : ST_PAY;
              end
            end
          end
          ST_PAY: begin
            if (strobe) begin
              for (int i = 0; i < MAX_LEN; i++) begin
                if (idx == i[3:0]) cmd_payload[i*8 +: 8] <= rx_data;
              end
              idx <= idx + 4'd1;
              if (idx == cmd_len - 4'd1) state <= ST_CHK;
            end
          end
          ST_CHK: begin
            if (strobe) begin
              if (chk_match) begin
                cmd_valid <= 1'b1;
                state     <= ST_HOLD;
              end else begin
                err_pulse <= 1'b1;
                err_code  <= ERR_CHK;
                state     <= ST_IDLE;
              end
            end
          end
          ST_HOLD: begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state     <= ST_IDLE;
            end
            if (strobe) begin
              err_pulse <= 1'b1;
              err_code  <= ERR_OVR;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
